// File: rtl/mem_arbiter_if.sv
// Bus bundle between the fetch port, the load/store port, the shared memory
// and the arbiter. The arbiter uses the slave view; the requesters and the
// memory model sit on the master view.
interface mem_arbiter_if;
    // Instruction-fetch port
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_gnt;
    logic        i_rvalid;
    logic [31:0] i_rdata;
    logic        i_err;

    // Load/store port
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        d_err;

    // Shared synchronous-read memory
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport master (
        output i_req, i_addr,
        input  i_gnt, i_rvalid, i_rdata, i_err,
        output d_req, d_we, d_be, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata, d_err,
        input  mem_addr, mem_we, mem_be, mem_wdata,
        output mem_rdata
    );

    modport slave (
        input  i_req, i_addr,
        output i_gnt, i_rvalid, i_rdata, i_err,
        input  d_req, d_we, d_be, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata, d_err,
        output mem_addr, mem_we, mem_be, mem_wdata,
        input  mem_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of one synchronous-read memory. D normally wins,
// but after MAX_D_STREAK consecutive D grants with a fetch waiting, the fetch
// is forced through. Responses come back one cycle after the grant, routed by
// a small owner register; out-of-range accesses are granted but never touch
// memory and answer with err=1, rdata=0.
module mem_arbiter #(
    parameter int unsigned MEM_BYTES    = 16384,
    parameter int unsigned MAX_D_STREAK = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    mem_arbiter_if.slave bus
);

    localparam int unsigned STREAK_W = $clog2(MAX_D_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } owner_e;

    owner_e              owner_q, owner_d;
    logic                err_q, err_d;
    logic                we_q, we_d;
    logic [STREAK_W-1:0] streak_q, streak_d;

    logic i_gnt;
    logic d_gnt;
    logic i_oob;
    logic d_oob;

    assign i_oob = (bus.i_addr >= 32'(MEM_BYTES));
    assign d_oob = (bus.d_addr >= 32'(MEM_BYTES));

    // Pick at most one winner; D wins contention until the streak limit is hit.
    always_comb begin
        i_gnt = 1'b0;
        d_gnt = 1'b0;
        if (rst_n) begin
            if (bus.d_req && (!bus.i_req || (streak_q != STREAK_MAX))) begin
                d_gnt = 1'b1;
            end else if (bus.i_req) begin
                i_gnt = 1'b1;
            end
        end
    end

    // Count D wins while a fetch is waiting; any fetch grant or idle fetch resets it.
    always_comb begin
        streak_d = streak_q;
        if (!bus.i_req || i_gnt) begin
            streak_d = '0;
        end else if (d_gnt && (streak_q != STREAK_MAX)) begin
            streak_d = streak_q + 1'b1;
        end
    end

    // Steer the winner onto the memory bus; idle cycles present the fetch address.
    always_comb begin
        bus.mem_addr  = bus.i_addr & ~32'h3;
        bus.mem_we    = 1'b0;
        bus.mem_be    = 4'hF;
        bus.mem_wdata = '0;
        if (d_gnt) begin
            bus.mem_addr  = bus.d_addr & ~32'h3;
            bus.mem_we    = bus.d_we && !d_oob;
            bus.mem_be    = bus.d_be;
            bus.mem_wdata = bus.d_wdata;
        end
    end

    // Remember who was granted so next cycle's memory data goes back to them.
    always_comb begin
        owner_d = OWN_NONE;
        err_d   = 1'b0;
        we_d    = 1'b0;
        if (d_gnt) begin
            owner_d = OWN_D;
            err_d   = d_oob;
            we_d    = bus.d_we;
        end else if (i_gnt) begin
            owner_d = OWN_I;
            err_d   = i_oob;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            owner_q  <= OWN_NONE;
            err_q    <= 1'b0;
            we_q     <= 1'b0;
            streak_q <= '0;
        end else begin
            owner_q  <= owner_d;
            err_q    <= err_d;
            we_q     <= we_d;
            streak_q <= streak_d;
        end
    end

    assign bus.i_gnt = i_gnt;
    assign bus.d_gnt = d_gnt;

    // Responses are qualified by rst_n so a grant just before reset is dropped.
    assign bus.i_rvalid = rst_n && (owner_q == OWN_I);
    assign bus.d_rvalid = rst_n && (owner_q == OWN_D);
    assign bus.i_err    = bus.i_rvalid && err_q;
    assign bus.d_err    = bus.d_rvalid && err_q;
    assign bus.i_rdata  = (bus.i_rvalid && !err_q) ? bus.mem_rdata : 32'h0;
    assign bus.d_rdata  = (bus.d_rvalid && !err_q && !we_q) ? bus.mem_rdata : 32'h0;

endmodule
